// File: rtl/ddr3_loopback_traffic_generator.sv
// ddr3_loopback_traffic_generator
//
// Purpose: loopback traffic generator/checker placed in front of the DDR3
// memory controller. A pass writes NUM_OF_TEST_DATA pattern words to an
// address window that starts at START_ADDRESS. It then reads the same window
// back and compares every returned word against a regenerated copy of the
// pattern. Mismatches are counted, with saturation at 16'hFFFF, and the
// result is reported through done/pass.
//
// Optional feature: define LOOPBACK_ERROR_LOG_EN to capture the read address,
// the expected word and the actual word of the first mismatch of a pass into
// first_err_*. When the macro is undefined those outputs are tied to 0 and no
// capture registers exist.
//
// Ports (AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH):
//   clk                  in   single clock
//   resetn               in   synchronous, active-low reset
//   start                in   1-cycle request to begin a pass (ignored while busy)
//   pattern_mode         in   [1:0] 0=incrementing 1=LFSR 2=walking one 3=address
//   write_enable         out  write request to controller
//   read_enable          out  read request to controller
//   i_user_data_address  out  [AW-1:0] current write/read address
//   data_to_ram          out  [DQ-1:0] current write word
//   wr_accept            in   controller consumed current write address/data
//   rd_accept            in   controller consumed current read address
//   rd_data_valid        in   data_from_ram valid this cycle
//   data_from_ram        in   [DQ-1:0] returned read word
//   busy / done / pass   out  pass status; pass is meaningful while done=1
//   error_count          out  [15:0] saturating mismatch count
//   first_err_address    out  [AW-1:0] first mismatch address
//   first_err_expected   out  [DQ-1:0] first mismatch expected word
//   first_err_actual     out  [DQ-1:0] first mismatch returned word
//   dbg_state            out  [1:0] FSM state (IDLE=0, WRITE=1, READ=2, DONE=3)
//
// Handshake: a write word is transferred on any cycle where write_enable and
// wr_accept are both 1; address/data move to the next word in the following
// cycle. A read address is transferred on any cycle where read_enable and
// rd_accept are both 1. Returned data is taken on each rd_data_valid while in
// READ. There is no back-pressure on the return path, and the returns must
// arrive in issue order.

module ddr3_loopback_traffic_generator #(
    parameter int DQ_BITWIDTH           = 16,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int NUM_OF_TEST_DATA      = 8,
    parameter logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] START_ADDRESS = '0
) (
    input  logic                                             clk,
    input  logic                                             resetn,
    input  logic                                             start,
    input  logic [1:0]                                       pattern_mode,
    output logic                                             write_enable,
    output logic                                             read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                           data_to_ram,
    input  logic                                             wr_accept,
    input  logic                                             rd_accept,
    input  logic                                             rd_data_valid,
    input  logic [DQ_BITWIDTH-1:0]                           data_from_ram,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             pass,
    output logic [15:0]                                      error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_err_address,
    output logic [DQ_BITWIDTH-1:0]                           first_err_expected,
    output logic [DQ_BITWIDTH-1:0]                           first_err_actual,
    output logic [1:0]                                       dbg_state
);

    localparam int AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int DQ    = DQ_BITWIDTH;
    localparam int LANES = DQ / 8;
    // Only the LFSR bits that can reach the data bus are passed to the
    // pattern function; wider buses replicate these 32 bits.
    localparam int LW    = (DQ < 32) ? DQ : 32;
    // Number of address bits that fit on the data bus in address-as-data mode.
    localparam int ACOPY = (AW < DQ) ? AW : DQ;

    localparam logic [15:0]   LAST_IDX  = 16'(NUM_OF_TEST_DATA - 1);
    localparam logic [15:0]   NUM_WORDS = 16'(NUM_OF_TEST_DATA);
    localparam logic [31:0]   LFSR_SEED = 32'hACE1ACE1;
    // Right-shift Galois toggle mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0]   LFSR_TAPS = 32'h80200003;
    localparam logic [DQ-1:0] WALK_INIT = {{(DQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;

    // Issue side: index/address for writes, reused for read issue.
    logic [15:0]     iss_idx_q, iss_idx_d;
    logic [31:0]     iss_lfsr_q, iss_lfsr_d;
    logic [DQ-1:0]   iss_walk_q, iss_walk_d;
    logic [AW-1:0]   iss_addr_q, iss_addr_d;

    // Receive side: an independent generator that tracks returned words.
    logic [15:0]     rx_idx_q, rx_idx_d;
    logic [31:0]     rx_lfsr_q, rx_lfsr_d;
    logic [DQ-1:0]   rx_walk_q, rx_walk_d;
    logic [AW-1:0]   rx_addr_q, rx_addr_d;

    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            start_accept;
    logic            rx_fire;
    logic            mismatch;
    logic [DQ-1:0]   rx_expected;
    logic [DQ-1:0]   iss_word;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DQ-1:0] walk_rotate(input logic [DQ-1:0] w);
        return {w[DQ-2:0], w[DQ-1]};
    endfunction

    function automatic logic [DQ-1:0] pattern_word(
        input logic [1:0]       mode,
        input logic [7:0]       idx_lo,
        input logic [LW-1:0]    lfsr_lo,
        input logic [DQ-1:0]    walk,
        input logic [ACOPY-1:0] addr_lo
    );
        logic [DQ-1:0] w;
        w = '0;
        case (mode)
            2'd0: begin
                for (int k = 0; k < LANES; k++) begin
                    w[8*k +: 8] = idx_lo + 8'(k);
                end
            end
            2'd1: begin
                for (int b = 0; b < DQ; b++) begin
                    w[b] = lfsr_lo[b % LW];
                end
            end
            2'd2: begin
                w = walk;
            end
            default: begin
                for (int b = 0; b < ACOPY; b++) begin
                    w[b] = addr_lo[b];
                end
            end
        endcase
        return w;
    endfunction

    assign iss_word    = pattern_word(mode_q, iss_idx_q[7:0], iss_lfsr_q[LW-1:0],
                                      iss_walk_q, iss_addr_q[ACOPY-1:0]);
    assign rx_expected = pattern_word(mode_q, rx_idx_q[7:0], rx_lfsr_q[LW-1:0],
                                      rx_walk_q, rx_addr_q[ACOPY-1:0]);

    // The FSM leaves READ on the last receive, so any return taken in READ is
    // within the expected count. Extra or stray returns are dropped here.
    assign rx_fire      = (state_q == S_READ) && rd_data_valid;
    assign mismatch     = rx_fire && (data_from_ram != rx_expected);
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        iss_idx_d    = iss_idx_q;
        iss_lfsr_d   = iss_lfsr_q;
        iss_walk_d   = iss_walk_q;
        iss_addr_d   = iss_addr_q;
        rx_idx_d     = rx_idx_q;
        rx_lfsr_d    = rx_lfsr_q;
        rx_walk_d    = rx_walk_q;
        rx_addr_d    = rx_addr_q;
        err_cnt_d    = err_cnt_q;
        write_enable = 1'b0;
        read_enable  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accept) begin
                    state_d    = S_WRITE;
                    mode_d     = pattern_mode;
                    iss_idx_d  = '0;
                    iss_lfsr_d = LFSR_SEED;
                    iss_walk_d = WALK_INIT;
                    iss_addr_d = START_ADDRESS;
                    rx_idx_d   = '0;
                    rx_lfsr_d  = LFSR_SEED;
                    rx_walk_d  = WALK_INIT;
                    rx_addr_d  = START_ADDRESS;
                    err_cnt_d  = '0;
                end
            end

            S_WRITE: begin
                write_enable = 1'b1;
                if (wr_accept) begin
                    if (iss_idx_q == LAST_IDX) begin
                        // The read issue reuses the index/address counters.
                        state_d    = S_READ;
                        iss_idx_d  = '0;
                        iss_addr_d = START_ADDRESS;
                    end else begin
                        iss_idx_d  = iss_idx_q + 16'd1;
                        iss_lfsr_d = lfsr_step(iss_lfsr_q);
                        iss_walk_d = walk_rotate(iss_walk_q);
                        iss_addr_d = iss_addr_q + AW'(1);
                    end
                end
            end

            S_READ: begin
                read_enable = (iss_idx_q != NUM_WORDS);
                if (read_enable && rd_accept) begin
                    iss_idx_d  = iss_idx_q + 16'd1;
                    iss_addr_d = iss_addr_q + AW'(1);
                end
                if (rx_fire) begin
                    rx_idx_d  = rx_idx_q + 16'd1;
                    rx_lfsr_d = lfsr_step(rx_lfsr_q);
                    rx_walk_d = walk_rotate(rx_walk_q);
                    rx_addr_d = rx_addr_q + AW'(1);
                    if (mismatch && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (rx_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            iss_idx_q  <= '0;
            iss_lfsr_q <= '0;
            iss_walk_q <= '0;
            iss_addr_q <= '0;
            rx_idx_q   <= '0;
            rx_lfsr_q  <= '0;
            rx_walk_q  <= '0;
            rx_addr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            iss_idx_q  <= iss_idx_d;
            iss_lfsr_q <= iss_lfsr_d;
            iss_walk_q <= iss_walk_d;
            iss_addr_q <= iss_addr_d;
            rx_idx_q   <= rx_idx_d;
            rx_lfsr_q  <= rx_lfsr_d;
            rx_walk_q  <= rx_walk_d;
            rx_addr_q  <= rx_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign i_user_data_address = iss_addr_q;
    // The data bus is only driven with a pattern while writing. This keeps it
    // at 0 after reset and between passes.
    assign data_to_ram         = write_enable ? iss_word : '0;
    assign busy                = (state_q == S_WRITE) || (state_q == S_READ);
    assign done                = (state_q == S_DONE);
    assign pass                = (state_q == S_DONE) && (err_cnt_q == 16'd0);
    assign error_count         = err_cnt_q;
    assign dbg_state           = state_q;

`ifdef LOOPBACK_ERROR_LOG_EN
    logic [AW-1:0] ferr_addr_q, ferr_addr_d;
    logic [DQ-1:0] ferr_exp_q, ferr_exp_d;
    logic [DQ-1:0] ferr_act_q, ferr_act_d;

    // err_cnt_q is cleared on every accepted start, so a zero count means that
    // this mismatch is the first one of the pass.
    always_comb begin
        ferr_addr_d = ferr_addr_q;
        ferr_exp_d  = ferr_exp_q;
        ferr_act_d  = ferr_act_q;
        if (start_accept) begin
            ferr_addr_d = '0;
            ferr_exp_d  = '0;
            ferr_act_d  = '0;
        end else if (mismatch && (err_cnt_q == 16'd0)) begin
            ferr_addr_d = rx_addr_q;
            ferr_exp_d  = rx_expected;
            ferr_act_d  = data_from_ram;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ferr_addr_q <= '0;
            ferr_exp_q  <= '0;
            ferr_act_q  <= '0;
        end else begin
            ferr_addr_q <= ferr_addr_d;
            ferr_exp_q  <= ferr_exp_d;
            ferr_act_q  <= ferr_act_d;
        end
    end

    assign first_err_address  = ferr_addr_q;
    assign first_err_expected = ferr_exp_q;
    assign first_err_actual   = ferr_act_q;
`else
    assign first_err_address  = '0;
    assign first_err_expected = '0;
    assign first_err_actual   = '0;
`endif

endmodule

// File: doc/ddr3_loopback_traffic_generator.md
# ddr3_loopback_traffic_generator

Parametrised DDR3 loopback traffic generator and checker that sits between the board-level test top and `ddr3_memory_controller`. It writes a configurable number of pattern words to a configurable address window, then reads the window back and checks each returned word against a regenerated copy of the pattern. It counts mismatches and reports pass/fail. It replaces the fixed 8-word incrementing loopback with selectable patterns, a handshake with the controller, and error reporting.

## Interface
Parameters:
- `DQ_BITWIDTH`, 16, data width; must be a multiple of 8.
- `BANK_ADDRESS_BITWIDTH`, 3, bank address bits.
- `ADDRESS_BITWIDTH`, 14, row/column address bits.
- `NUM_OF_TEST_DATA`, 8, words per pass; range 1..65535.
- `START_ADDRESS`, 0, first address of the window (width `BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH`).

Ports (`AW = BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH`):
- `clk`  in  1  single clock.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  1-cycle request to begin a pass.
- `pattern_mode`  in  2  pattern select; sampled on an accepted `start`.
- `write_enable`  out  1  write request to controller.
- `read_enable`  out  1  read request to controller.
- `i_user_data_address`  out  AW  current write/read address.
- `data_to_ram`  out  DQ_BITWIDTH  current write word.
- `wr_accept`  in  1  controller consumed the current write address/data this cycle.
- `rd_accept`  in  1  controller consumed the current read address this cycle.
- `rd_data_valid`  in  1  `data_from_ram` is valid this cycle.
- `data_from_ram`  in  DQ_BITWIDTH  returned read word.
- `busy`  out  1  pass in progress.
- `done`  out  1  pass complete.
- `pass`  out  1  valid while `done`=1; 1 when `error_count`=0.
- `error_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `first_err_address`, `first_err_expected`, `first_err_actual`  out  AW/DQ/DQ  see Configuration.

## Operation
- Reset (`resetn`=0 at `clk` rising edge) clears all outputs to 0 and the FSM to IDLE. Reset is honoured in any state, including mid-pass.
- FSM states: IDLE → WRITE → READ → DONE.
  - **IDLE**: on `start`, latch `pattern_mode`, clear counters and error state, then go to WRITE. Address = `START_ADDRESS`, index = 0.
  - **WRITE**: `write_enable`=1.
    - Each `wr_accept` advances the index, increments the address, and presents the next pattern word.
    - After the `NUM_OF_TEST_DATA`-th accept, go to READ. The address reloads to `START_ADDRESS` and the issue index resets to 0.
  - **READ**: `read_enable`=1 until `NUM_OF_TEST_DATA` `rd_accept`s have occurred, then 0.
    - A separate receive index and expected-pattern generator advance on each `rd_data_valid`. A mismatch increments `error_count`, which saturates.
    - After `NUM_OF_TEST_DATA` receives, go to DONE.
  - **DONE**: `done`=1 and `pass` valid; both hold until the next `start`, which begins a new pass directly from DONE.
- `start` while `busy` is ignored.
- `rd_data_valid` in IDLE, WRITE or DONE, or beyond `NUM_OF_TEST_DATA` receives, is ignored.
- `rd_accept` and `rd_data_valid` in the same cycle are both processed.
- Address arithmetic is modulo 2^AW; the window wraps past all-ones to 0.
- Pattern word for index i (lanes = DQ_BITWIDTH/8):
  - mode 0, incrementing: byte lane k = (i+k) mod 256.
  - mode 1, LFSR: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed 32'hACE1ACE1, advanced once per word; data = low DQ_BITWIDTH bits (replicated if DQ_BITWIDTH>32).
  - mode 2, walking one: 1 << (i mod DQ_BITWIDTH).
  - mode 3, address as data: address zero-extended or truncated to DQ_BITWIDTH.

## Timing
- `start` → `busy`=1 and `write_enable`=1 on the next cycle, with the first word and address already valid.
- `wr_accept` in cycle n → new address and data in cycle n+1. Back-to-back accepts every cycle are supported.
- Last `wr_accept` in cycle n → `write_enable`=0 and `read_enable`=1 in cycle n+1.
- The last receive in cycle n has its compare applied in that cycle → `done`=1, `busy`=0, with final `error_count` and `pass` in cycle n+1.
- The number of outstanding reads is unbounded by this block; the controller is responsible for returning reads in order.

## Configuration
- `LOOPBACK_ERROR_LOG_EN` defined: on the first mismatch of a pass, latch the read address, the expected word and the actual word into `first_err_*`. These registers are cleared on `start` and on reset.
- `LOOPBACK_ERROR_LOG_EN` undefined: `first_err_*` are tied to 0 and no capture registers exist.

## Test plan
- Mode 0, DQ=16, N=8, `wr_accept`/`rd_accept` held high, ideal memory → `data_to_ram` sequence 16'h0100, 16'h0201 … 16'h0807; `done` after 8 receives; `pass`=1; `error_count`=0.
- Mode 1 with random accept stalls and read latency of 1–20 cycles → `pass`=1; expected values match the LFSR from seed 32'hACE1ACE1.
- Mode 3 with bit 3 of word 5 corrupted on readback → `error_count`=1; with `LOOPBACK_ERROR_LOG_EN`, `first_err_address`=`START_ADDRESS`+5 and `first_err_actual` = expected ^ 16'h0008.
- `START_ADDRESS`=2^AW−2, N=4 → addresses 2^AW−2, 2^AW−1, 0, 1 in both WRITE and READ.
- `resetn`=0 midway through READ, then `start` → all outputs 0 the cycle after reset; the new pass completes with `pass`=1. A `start` pulse while `busy` has no effect.
